// File: rtl/reg_file_ctrl.sv
// Command-side initiator for reg_file: clears the array, then executes read/write/copy
// commands one at a time and returns read results over a valid/ready response channel.
module reg_file_ctrl #(
    parameter int W = 5,
    parameter int B = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_start,
    output logic         busy,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_addr,
    input  logic [W-1:0] cmd_src,
    input  logic [B-1:0] cmd_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [B-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic         rf_wr_en,
    output logic [W-1:0] rf_w_addr,
    output logic [B-1:0] rf_w_data,
    output logic [W-1:0] rf_r_addr_A,
    output logic [W-1:0] rf_r_addr_B,
    input  logic [B-1:0] rf_r_data_A,
    input  logic [B-1:0] rf_r_data_B
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_EXEC  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [W-1:0] CNT_LAST = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [1:0]   op_q, op_d;
    logic [W-1:0] addr_q, addr_d;
    logic [B-1:0] wdata_q, wdata_d;
    logic [W-1:0] r_addr_a_q, r_addr_a_d;
    logic [W-1:0] r_addr_b_q, r_addr_b_d;
    logic [B-1:0] rsp_rdata_q, rsp_rdata_d;
    logic         rsp_err_q, rsp_err_d;
    logic         accept_s;

    // clr_start pre-empts a simultaneous command, so it also gates the ready
    assign cmd_ready = (state_q == S_IDLE) && !clr_start;
    assign accept_s  = cmd_valid && cmd_ready;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            cnt_q       <= '0;
            op_q        <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            r_addr_a_q  <= '0;
            r_addr_b_q  <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            r_addr_a_q  <= r_addr_a_d;
            r_addr_b_q  <= r_addr_b_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: begin
                if (cnt_q == CNT_LAST) state_d = S_IDLE;
                else                   state_d = S_CLEAR;
            end
            S_IDLE: begin
                if (clr_start)     state_d = S_CLEAR;
                else if (accept_s) state_d = S_EXEC;
                else               state_d = S_IDLE;
            end
            S_EXEC: begin
                if (op_q == OP_WRITE || op_q == OP_COPY) state_d = S_IDLE;
                else                                     state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
                else           state_d = S_RESP;
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // Command latch, read-address hold and response capture
    always_comb begin
        cnt_d       = (state_q == S_CLEAR) ? cnt_q + CNT_ONE : {W{1'b0}};
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        r_addr_a_d  = r_addr_a_q;
        r_addr_b_d  = r_addr_b_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept_s) begin
            op_d    = cmd_op;
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
            if (cmd_op == OP_READ) r_addr_a_d = cmd_addr;
            else                   r_addr_a_d = r_addr_a_q;
            if (cmd_op == OP_COPY) r_addr_b_d = cmd_src;
            else                   r_addr_b_d = r_addr_b_q;
        end else begin
            op_d = op_q;
        end
        if (state_q == S_EXEC && op_q == OP_READ) begin
            rsp_rdata_d = rf_r_data_A;
            rsp_err_d   = 1'b0;
        end else if (state_q == S_EXEC && op_q != OP_WRITE && op_q != OP_COPY) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
        end else begin
            rsp_err_d = rsp_err_q;
        end
    end

    // Output decode; write enable is suppressed while reset is held
    always_comb begin
        rf_wr_en  = 1'b0;
        rf_w_addr = addr_q;
        rf_w_data = '0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_CLEAR: begin
                rf_wr_en  = !reset;
                rf_w_addr = cnt_q;
            end
            S_IDLE: begin
                busy = 1'b0;
            end
            S_EXEC: begin
                if (op_q == OP_WRITE) begin
                    rf_wr_en  = !reset;
                    rf_w_data = wdata_q;
                end else if (op_q == OP_COPY) begin
                    rf_wr_en  = !reset;
                    rf_w_data = rf_r_data_B;
                end else begin
                    rf_wr_en = 1'b0;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rf_r_addr_A = r_addr_a_q;
    assign rf_r_addr_B = r_addr_b_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed self-checking bench for reg_file_ctrl with a behavioural reg_file attached.
module tb_reg_file_ctrl;

    logic        clk = 1'b0;
    logic        reset, clr_start, busy;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_addr, cmd_src;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        rf_wr_en;
    logic [4:0]  rf_w_addr, rf_r_addr_A, rf_r_addr_B;
    logic [31:0] rf_w_data, rf_r_data_A, rf_r_data_B;

    logic [31:0] mem [32];
    int n_chk = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int rsp_cnt = 0;
    int wr_snap, rsp_snap;

    always #5 clk = ~clk;

    reg_file_ctrl #(.W(5), .B(32)) dut (
        .clk(clk), .reset(reset), .clr_start(clr_start), .busy(busy),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_src(cmd_src), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rf_wr_en(rf_wr_en), .rf_w_addr(rf_w_addr),
        .rf_w_data(rf_w_data), .rf_r_addr_A(rf_r_addr_A), .rf_r_addr_B(rf_r_addr_B),
        .rf_r_data_A(rf_r_data_A), .rf_r_data_B(rf_r_data_B)
    );

    // Behavioural reg_file plus write / response event counters
    always @(posedge clk) begin
        if (rf_wr_en) begin
            mem[rf_w_addr] <= rf_w_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
    end
    assign rf_r_data_A = mem[rf_r_addr_A];
    assign rf_r_data_B = mem[rf_r_addr_B];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_seq(input string tag);
        for (int i = 0; i < 32; i++) begin
            check_eq({tag, "_wr_en"}, {31'd0, rf_wr_en}, 32'd1);
            check_eq({tag, "_w_addr"}, {27'd0, rf_w_addr}, i);
            check_eq({tag, "_w_data"}, rf_w_data, 32'd0);
            check_eq({tag, "_ready_low"}, {31'd0, cmd_ready}, 32'd0);
            tick();
        end
        check_eq({tag, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [4:0] s, input logic [31:0] d);
        cmd_op = op; cmd_addr = a; cmd_src = s; cmd_wdata = d; cmd_valid = 1'b1;
        #1;
        check_eq("accept_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        send(2'b01, a, 5'd0, d);
        check_eq("wr_en", {31'd0, rf_wr_en}, 32'd1);
        check_eq("wr_addr", {27'd0, rf_w_addr}, {27'd0, a});
        check_eq("wr_data", rf_w_data, d);
        tick();
    endtask

    task automatic do_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
        rsp_ready = 1'b1;
        send(2'b00, a, 5'd0, 32'd0);
        check_eq({tag, "_valid_c1"}, {31'd0, rsp_valid}, 32'd0);
        tick();
        check_eq({tag, "_valid_c2"}, {31'd0, rsp_valid}, 32'd1);
        check_eq({tag, "_rdata"}, rsp_rdata, exp);
        check_eq({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
        tick();
        check_eq({tag, "_valid_done"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; clr_start = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
        cmd_addr = 5'd0; cmd_src = 5'd0; cmd_wdata = 32'd0; rsp_ready = 1'b1;

        // 1: reset state, full clear, reads return zero
        tick();
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd1);
        check_eq("rst_w_addr", {27'd0, rf_w_addr}, 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        check_eq("rst_r_addr_a", {27'd0, rf_r_addr_A}, 32'd0);
        reset = 1'b0;
        #1;
        clear_seq("clr1");
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        do_read(5'd0, 32'd0, "rd0_zero");
        do_read(5'd17, 32'd0, "rd17_zero");
        do_read(5'd31, 32'd0, "rd31_zero");

        // 2: writes then reads, read-after-write
        do_write(5'd0, 32'd10);
        do_write(5'd1, 32'd15);
        do_read(5'd0, 32'd10, "rd0");
        do_read(5'd1, 32'd15, "rd1");

        // 3: copy
        do_write(5'd20, 32'd100);
        send(2'b10, 5'd21, 5'd20, 32'd0);
        check_eq("copy_wr_en", {31'd0, rf_wr_en}, 32'd1);
        check_eq("copy_w_addr", {27'd0, rf_w_addr}, 32'd21);
        check_eq("copy_w_data", rf_w_data, 32'd100);
        tick();
        do_read(5'd21, 32'd100, "rd21_copy");
        do_read(5'd20, 32'd100, "rd20_src");

        // 4: response back-pressure
        rsp_ready = 1'b0;
        rsp_snap = rsp_cnt;
        send(2'b00, 5'd20, 5'd0, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("bp_rdata", rsp_rdata, 32'd100);
            check_eq("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check_eq("bp_valid_done", {31'd0, rsp_valid}, 32'd0);
        check_eq("bp_single_rsp", rsp_cnt, rsp_snap + 1);

        // 5: reserved op, then clr_start colliding with a command
        wr_snap = wr_cnt;
        send(2'b11, 5'd5, 5'd0, 32'hdead_beef);
        check_eq("rsv_wr_en", {31'd0, rf_wr_en}, 32'd0);
        tick();
        check_eq("rsv_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("rsv_err", {31'd0, rsp_err}, 32'd1);
        check_eq("rsv_rdata", rsp_rdata, 32'd0);
        tick();
        check_eq("rsv_no_write", wr_cnt, wr_snap);
        rsp_snap = rsp_cnt;
        clr_start = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 5'd20;
        #1;
        check_eq("clr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        clr_start = 1'b0; cmd_valid = 1'b0;
        clear_seq("clr2");
        check_eq("clr_no_rsp", rsp_cnt, rsp_snap);
        do_read(5'd20, 32'd0, "rd20_cleared");

        // 6a: reset during clear cycle 10
        do_write(5'd3, 32'd7);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("mid_clr_addr", {27'd0, rf_w_addr}, 32'd10);
        reset = 1'b1;
        tick();
        check_eq("mid_clr_rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check_eq("mid_clr_rst_addr", {27'd0, rf_w_addr}, 32'd0);
        reset = 1'b0;
        #1;
        clear_seq("clr3");

        // 6b: reset while a response is pending
        rsp_ready = 1'b0;
        send(2'b00, 5'd3, 5'd0, 32'd0);
        tick();
        check_eq("pend_valid", {31'd0, rsp_valid}, 32'd1);
        reset = 1'b1;
        tick();
        check_eq("pend_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("pend_rst_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        #1;
        clear_seq("clr4");
        do_read(5'd3, 32'd0, "rd3_after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_file_ctrl.md
Name: reg_file_ctrl

Overview:
Command-side initiator for the team's `reg_file` (2^W x B, one write port, two combinational read ports). It accepts read, write and copy commands over a valid/ready handshake and drives the reg_file write and read ports. It returns read data over a valid/ready response channel. After reset, or on request, it clears the whole array to zero before accepting any command.

Parameters:
W, 5, address width; depth = 2^W
B, 32, data width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
clr_start  input  1  one-cycle pulse; re-runs the clear sequence (honoured only in IDLE)
busy  output  1  high while clearing or executing
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  2  00 read, 01 write, 10 copy, 11 reserved
cmd_addr  input  W  read/write address; destination for copy
cmd_src  input  W  source address for copy
cmd_wdata  input  B  write data
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  B  read data
rsp_err  output  1  response is for a reserved op
rf_wr_en  output  1  to reg_file wr_en
rf_w_addr  output  W  to reg_file w_addr
rf_w_data  output  B  to reg_file w_data
rf_r_addr_A  output  W  to reg_file r_addr_A
rf_r_addr_B  output  W  to reg_file r_addr_B
rf_r_data_A  input  B  from reg_file r_data_A (combinational read)
rf_r_data_B  input  B  from reg_file r_data_B (combinational read)

Behaviour:
- One clock, clk; reset is synchronous and active-high. Both are fixed.
- Reset state: state=CLEAR, clear counter=0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - rf_wr_en=0; all rf addresses and rf_w_data are 0.
  - cmd_ready=0, busy=1.
- Reset mid-operation: aborts everything, including a pending response, and restarts CLEAR.
- FSM states: CLEAR, IDLE, EXEC, RESP.
- CLEAR:
  - Each cycle: rf_wr_en=1, rf_w_addr=counter, rf_w_data=0; counter increments.
  - After the write to address 2^W-1 (2^W cycles), the counter wraps to 0 and the FSM goes to IDLE.
  - cmd_ready=0 throughout.
- IDLE:
  - cmd_ready=1, busy=0, rf_wr_en=0.
  - Handshake when cmd_valid and cmd_ready are both high at the rising edge. The command is latched and the FSM goes to EXEC.
  - clr_start in IDLE goes to CLEAR. If cmd_valid and clr_start are asserted together, clr_start wins and the command is not accepted (cmd_ready is forced 0 that cycle).
- EXEC (exactly one cycle; cmd_ready=0):
  - write: rf_wr_en=1, rf_w_addr=addr, rf_w_data=wdata. Then to IDLE. No response.
  - read: rf_r_addr_A=addr. rf_r_data_A is captured into rsp_rdata at the end of EXEC; rsp_err=0. Then to RESP.
  - copy: rf_r_addr_B=src, rf_wr_en=1, rf_w_addr=addr, rf_w_data=rf_r_data_B. Then to IDLE. copy with src==addr is a legal no-op rewrite.
  - reserved: no rf write; rsp_rdata=0, rsp_err=1. Then to RESP.
- RESP:
  - rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_ready.
  - On rsp_valid and rsp_ready: rsp_valid=0 and the FSM goes to IDLE on the next cycle.
  - clr_start is ignored outside IDLE.
- Latency, accept edge to response:
  - write: committed at the end of the cycle after accept.
  - read: rsp_valid is high 2 cycles after the accept edge.
  - Throughput: one command per 2 cycles (write/copy); at least 3 cycles per read.
- Read-after-write: a read accepted immediately after a write returns the new data, because the write commits before the read's EXEC.
- Addresses wrap naturally at W bits; there is no range check.
- rf_r_addr_A and rf_r_addr_B hold their last value when unused.

Test Plan:
1. Reset 1 cycle, then release. Required: cmd_ready=0 for exactly 32 cycles, rf_wr_en=1 with w_addr 0..31 and data 0, then cmd_ready=1. Reading addresses 0, 17 and 31 returns 0.
2. Write (0,10) and (1,15), then read 0 and read 1 with rsp_ready=1. Required: rsp_rdata=10 then 15, rsp_err=0, and each rsp_valid is exactly 2 cycles after its accept.
3. Write (20,100), copy src=20 to dst=21, read 21. Required: rsp_rdata=100, and address 20 still reads 100.
4. Read 20 with rsp_ready held low for 4 cycles. Required: rsp_valid=1 with rsp_rdata=100 stable all 4 cycles, cmd_ready=0 throughout, and a single response delivered when rsp_ready rises.
5. cmd_op=11 with addr=5. Required: no rf_wr_en pulse, response with rsp_err=1 and rsp_rdata=0. Then assert clr_start and cmd_valid together in IDLE. Required: the command is not accepted, 32 clear cycles run, and a later read of 20 returns 0.
6. Assert reset during CLEAR cycle 10, and separately while rsp_valid=1. Required: rsp_valid drops next cycle, CLEAR restarts from address 0, and the full 32-cycle clear occurs.
